// File: rtl/pipe_pkg.sv
// Shared widths, ALU function codes and instruction types for the pipelined ALU and its issue stage.
package pipe_pkg;

  localparam int unsigned REG_W  = 4;
  localparam int unsigned FUNC_W = 4;
  localparam int unsigned ADDR_W = 8;

  localparam logic [FUNC_W-1:0] ADD = 4'd0;
  localparam logic [FUNC_W-1:0] SUB = 4'd1;
  localparam logic [FUNC_W-1:0] MUL = 4'd2;
  localparam logic [FUNC_W-1:0] SLA = 4'd11;
  localparam logic [FUNC_W-1:0] NOP = 4'd15;

  typedef struct packed {
    logic [REG_W-1:0]  rs1;
    logic [REG_W-1:0]  rs2;
    logic [REG_W-1:0]  rd;
    logic [FUNC_W-1:0] func;
    logic [ADDR_W-1:0] addr;
  } instr_t;

  typedef struct packed {
    logic             v;
    logic [REG_W-1:0] rd;
  } sb_entry_t;

  // True when either source operand of the instruction names register r.
  function automatic logic reads_reg(input instr_t ins, input logic [REG_W-1:0] r);
    return (ins.rs1 == r) || (ins.rs2 == r);
  endfunction

endpackage

// File: rtl/pipe_ififo.sv
// Synchronous instruction FIFO; pointers carry an extra MSB to tell full from empty.
module pipe_ififo
  import pipe_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   push,
  input  logic   pop,
  input  instr_t din,
  output logic   full,
  output logic   empty,
  output instr_t head
);

  localparam int unsigned AW = $clog2(DEPTH);

  instr_t      mem_q [DEPTH];
  logic [AW:0] wptr_q, wptr_d;
  logic [AW:0] rptr_q, rptr_d;
  logic        do_push, do_pop;

  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign head  = mem_q[rptr_q[AW-1:0]];

  always_comb begin
    do_push = push && !full;
    do_pop  = pop && !empty;
    wptr_d  = wptr_q + {{AW{1'b0}}, do_push};
    rptr_d  = rptr_q + {{AW{1'b0}}, do_pop};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  // Storage needs no reset: entries are only read between push and pop.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wptr_q[AW-1:0]] <= din;
    end
  end

endmodule

// File: rtl/pipe_issue.sv
// Issue stage for the pipelined ALU: FIFO buffering plus RAW-hazard scoreboard with bubble insertion.
// Optional PIPE_ISSUE_STATS_EN adds saturating stall_cnt / issue_cnt counters.
module pipe_issue
  import pipe_pkg::*;
#(
  parameter int unsigned       DEPTH    = 4,
  parameter int unsigned       HAZ_WIN  = 2,
  parameter logic [FUNC_W-1:0] NOP_FUNC = NOP
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [REG_W-1:0]  in_rs1,
  input  logic [REG_W-1:0]  in_rs2,
  input  logic [REG_W-1:0]  in_rd,
  input  logic [FUNC_W-1:0] in_func,
  input  logic [ADDR_W-1:0] in_addr,
  output logic [REG_W-1:0]  rs1,
  output logic [REG_W-1:0]  rs2,
  output logic [REG_W-1:0]  rd,
  output logic [FUNC_W-1:0] func,
  output logic [ADDR_W-1:0] addr,
  output logic              issue_valid,
  output logic              hazard
`ifdef PIPE_ISSUE_STATS_EN
  ,
  output logic [15:0]       stall_cnt,
  output logic [15:0]       issue_cnt
`endif
);

  localparam instr_t OutRst = '{rs1: '0, rs2: '0, rd: '0, func: NOP_FUNC, addr: '0};

  instr_t                  in_instr, head;
  instr_t                  out_q, out_d;
  logic                    issue_valid_q, issue_valid_d;
  sb_entry_t [HAZ_WIN-1:0] sb_q, sb_d;
  logic                    full, empty, issue;

  assign in_instr = '{rs1: in_rs1, rs2: in_rs2, rd: in_rd, func: in_func, addr: in_addr};
  assign in_ready = !full;

  pipe_ififo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst_n(rst_n),
    .push (in_valid && in_ready),
    .pop  (issue),
    .din  (in_instr),
    .full (full),
    .empty(empty),
    .head (head)
  );

  // The pipe has no forwarding, so any live in-flight rd read by the head must wait.
  always_comb begin
    hazard = 1'b0;
    for (int i = 0; i < int'(HAZ_WIN); i++) begin
      if (sb_q[i].v && reads_reg(head, sb_q[i].rd)) begin
        hazard = 1'b1;
      end
    end
    if (empty) begin
      hazard = 1'b0;
    end
  end

  assign issue = !empty && !hazard;

  always_comb begin
    out_d         = out_q;
    out_d.func    = NOP_FUNC;
    issue_valid_d = 1'b0;
    sb_d[0]       = '{v: 1'b0, rd: '0};
    if (issue) begin
      out_d         = head;
      issue_valid_d = 1'b1;
      sb_d[0]       = '{v: 1'b1, rd: head.rd};
    end
    for (int i = 1; i < int'(HAZ_WIN); i++) begin
      sb_d[i] = sb_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q         <= OutRst;
      issue_valid_q <= 1'b0;
      sb_q          <= '0;
    end else begin
      out_q         <= out_d;
      issue_valid_q <= issue_valid_d;
      sb_q          <= sb_d;
    end
  end

  assign rs1         = out_q.rs1;
  assign rs2         = out_q.rs2;
  assign rd          = out_q.rd;
  assign func        = out_q.func;
  assign addr        = out_q.addr;
  assign issue_valid = issue_valid_q;

`ifdef PIPE_ISSUE_STATS_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic [15:0] issue_cnt_q, issue_cnt_d;

  // Only hazard bubbles count as stalls; an empty FIFO is starvation, not a stall.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    issue_cnt_d = issue_cnt_q;
    if (hazard && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
    if (issue && (issue_cnt_q != 16'hFFFF)) begin
      issue_cnt_d = issue_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      issue_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      issue_cnt_q <= issue_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign issue_cnt = issue_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_issue.sv
// Directed self-checking bench for pipe_issue (DEPTH=4, HAZ_WIN=2, NOP_FUNC=4'hF).
module tb_pipe_issue;
  import pipe_pkg::*;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [REG_W-1:0]  in_rs1 = '0, in_rs2 = '0, in_rd = '0;
  logic [FUNC_W-1:0] in_func = '0;
  logic [ADDR_W-1:0] in_addr = '0;
  logic [REG_W-1:0]  rs1, rs2, rd;
  logic [FUNC_W-1:0] func;
  logic [ADDR_W-1:0] addr;
  logic              issue_valid, hazard;
`ifdef PIPE_ISSUE_STATS_EN
  logic [15:0]       stall_cnt, issue_cnt;
`endif
  instr_t            issued;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipe_issue #(
    .DEPTH   (4),
    .HAZ_WIN (2),
    .NOP_FUNC(4'hF)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_rs1     (in_rs1),
    .in_rs2     (in_rs2),
    .in_rd      (in_rd),
    .in_func    (in_func),
    .in_addr    (in_addr),
    .rs1        (rs1),
    .rs2        (rs2),
    .rd         (rd),
    .func       (func),
    .addr       (addr),
    .issue_valid(issue_valid),
    .hazard     (hazard)
`ifdef PIPE_ISSUE_STATS_EN
    ,
    .stall_cnt  (stall_cnt),
    .issue_cnt  (issue_cnt)
`endif
  );

  assign issued = '{rs1: rs1, rs2: rs2, rd: rd, func: func, addr: addr};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input instr_t w);
    in_valid = 1'b1;
    in_rs1   = w.rs1;
    in_rs2   = w.rs2;
    in_rd    = w.rd;
    in_func  = w.func;
    in_addr  = w.addr;
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    in_valid = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  function automatic instr_t mk(input logic [3:0] s1, input logic [3:0] s2, input logic [3:0] d,
                                input logic [3:0] f, input logic [7:0] a);
    return '{rs1: s1, rs2: s2, rd: d, func: f, addr: a};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout, expected $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    instr_t i_add, i_mul, i_sla, i_sub14, i_sub15, i_sub15b;
    instr_t chain [7];
    instr_t gaps [3];
    instr_t model [$];
    instr_t exp_w;
    logic   accepted;
    int     widx, nissued;

    i_add    = mk(4'd3, 4'd5, 4'd10, ADD, 8'h10);
    i_mul    = mk(4'd3, 4'd8, 4'd12, MUL, 8'h20);
    i_sla    = mk(4'd7, 4'd3, 4'd13, SLA, 8'h30);
    i_sub14  = mk(4'd10, 4'd5, 4'd14, SUB, 8'h40);
    i_sub15  = mk(4'd10, 4'd5, 4'd15, SUB, 8'h50);
    i_sub15b = mk(4'd5, 4'd10, 4'd15, SUB, 8'h51);
    chain[0] = mk(4'd1, 4'd2, 4'd4, ADD, 8'h60);
    chain[1] = mk(4'd4, 4'd0, 4'd5, SUB, 8'h61);
    chain[2] = mk(4'd5, 4'd0, 4'd6, MUL, 8'h62);
    chain[3] = mk(4'd6, 4'd0, 4'd7, ADD, 8'h63);
    chain[4] = mk(4'd7, 4'd0, 4'd8, SLA, 8'h64);
    chain[5] = mk(4'd8, 4'd0, 4'd9, SUB, 8'h65);
    chain[6] = mk(4'd9, 4'd0, 4'd11, ADD, 8'h66);
    gaps[0]  = mk(4'd1, 4'd2, 4'd3, ADD, 8'h70);
    gaps[1]  = mk(4'd4, 4'd5, 4'd6, SUB, 8'h71);
    gaps[2]  = mk(4'd7, 4'd8, 4'd9, MUL, 8'h72);

    // Reset values
    #12;
    chk("rst_valid", 32'(issue_valid), 32'h0);
    chk("rst_func", 32'(func), 32'hF);
    chk("rst_fields", 32'({rs1, rs2, rd, addr}), 32'h0);
    chk("rst_ready", 32'(in_ready), 32'h1);
    chk("rst_hazard", 32'(hazard), 32'h0);

    // Independent stream issues back-to-back
    do_reset();
    drive(i_add);
    tick();
    chk("ind_hz0", 32'(hazard), 32'h0);
    drive(i_mul);
    tick();
    chk("ind_v0", 32'(issue_valid), 32'h1);
    chk("ind_w0", 32'(issued), 32'(i_add));
    drive(i_sla);
    tick();
    chk("ind_v1", 32'(issue_valid), 32'h1);
    chk("ind_w1", 32'(issued), 32'(i_mul));
    chk("ind_hz1", 32'(hazard), 32'h0);
    in_valid = 1'b0;
    tick();
    chk("ind_v2", 32'(issue_valid), 32'h1);
    chk("ind_w2", 32'(issued), 32'(i_sla));
    tick();
    chk("ind_idle_v", 32'(issue_valid), 32'h0);
    chk("ind_idle_func", 32'(func), 32'hF);
    chk("ind_idle_rd", 32'(rd), 32'd13);

    // One-bubble dependency: SUB reads r10 two issues after ADD
    do_reset();
    drive(i_add);
    tick();
    drive(i_mul);
    tick();
    chk("dep1_add", 32'(issued), 32'(i_add));
    drive(i_sub14);
    tick();
    chk("dep1_mul", 32'(issued), 32'(i_mul));
    chk("dep1_hz", 32'(hazard), 32'h1);
    in_valid = 1'b0;
    tick();
    chk("dep1_bub_v", 32'(issue_valid), 32'h0);
    chk("dep1_bub_func", 32'(func), 32'hF);
    chk("dep1_bub_rd", 32'(rd), 32'd12);
    chk("dep1_hz_clr", 32'(hazard), 32'h0);
    tick();
    chk("dep1_sub_v", 32'(issue_valid), 32'h1);
    chk("dep1_sub", 32'(issued), 32'(i_sub14));
`ifdef PIPE_ISSUE_STATS_EN
    chk("dep1_stall_cnt", 32'(stall_cnt), 32'd1);
    chk("dep1_issue_cnt", 32'(issue_cnt), 32'd3);
`endif

    // Two-bubble dependency, via rs1 then via rs2
    do_reset();
    drive(i_add);
    tick();
    drive(i_sub15);
    tick();
    chk("dep2a_add", 32'(issued), 32'(i_add));
    chk("dep2a_hz0", 32'(hazard), 32'h1);
    in_valid = 1'b0;
    tick();
    chk("dep2a_bub1", 32'(issue_valid), 32'h0);
    chk("dep2a_hz1", 32'(hazard), 32'h1);
    tick();
    chk("dep2a_bub2", 32'(issue_valid), 32'h0);
    chk("dep2a_hz2", 32'(hazard), 32'h0);
    tick();
    chk("dep2a_sub_v", 32'(issue_valid), 32'h1);
    chk("dep2a_sub", 32'(issued), 32'(i_sub15));
`ifdef PIPE_ISSUE_STATS_EN
    chk("dep2a_stall_cnt", 32'(stall_cnt), 32'd2);
    chk("dep2a_issue_cnt", 32'(issue_cnt), 32'd2);
`endif

    do_reset();
    drive(i_add);
    tick();
    drive(i_sub15b);
    tick();
    chk("dep2b_add", 32'(issued), 32'(i_add));
    in_valid = 1'b0;
    tick();
    chk("dep2b_bub1", 32'(issue_valid), 32'h0);
    tick();
    chk("dep2b_bub2", 32'(issue_valid), 32'h0);
    tick();
    chk("dep2b_sub", 32'(issued), 32'(i_sub15b));
    chk("dep2b_sub_v", 32'(issue_valid), 32'h1);

    // Full FIFO: a dependency chain issues one word per three cycles while in_valid stays high
    do_reset();
    widx    = 0;
    nissued = 0;
    drive(chain[0]);
    for (int cyc = 1; cyc <= 40; cyc++) begin
      accepted = in_valid && in_ready;
      tick();
      if (accepted) begin
        model.push_back(chain[widx]);
        widx++;
        if (widx < 7) drive(chain[widx]);
        else in_valid = 1'b0;
      end
      if (issue_valid) begin
        if (model.size() == 0) begin
          chk("full_extra_issue", 32'(issue_valid), 32'h0);
        end else begin
          exp_w = model.pop_front();
          chk("full_order", 32'(issued), 32'(exp_w));
        end
        nissued++;
      end
      if (cyc == 6) chk("full_ready_e6", 32'(in_ready), 32'h0);
      if (cyc == 7) chk("full_ready_e7", 32'(in_ready), 32'h0);
      if (cyc == 8) chk("full_ready_e8", 32'(in_ready), 32'h1);
      if (nissued == 7) break;
    end
    chk("full_issued", 32'(nissued), 32'd7);
    chk("full_pushed", 32'(widx), 32'd7);
    chk("full_left", 32'(model.size()), 32'd0);

    // Empty gaps: one push every three cycles
    do_reset();
    for (int k = 0; k < 3; k++) begin
      drive(gaps[k]);
      tick();
      in_valid = 1'b0;
      tick();
      chk("gap_v", 32'(issue_valid), 32'h1);
      chk("gap_w", 32'(issued), 32'(gaps[k]));
      tick();
      chk("gap_bub", 32'(issue_valid), 32'h0);
      chk("gap_hz", 32'(hazard), 32'h0);
    end
`ifdef PIPE_ISSUE_STATS_EN
    chk("gap_stall_cnt", 32'(stall_cnt), 32'd0);
    chk("gap_issue_cnt", 32'(issue_cnt), 32'd3);
`endif

    // Asynchronous reset mid-stream with three words queued
    do_reset();
    for (int k = 0; k < 5; k++) begin
      drive(chain[k]);
      tick();
    end
    chk("mid_pre_v", 32'(issue_valid), 32'h1);
    chk("mid_pre_w", 32'(issued), 32'(chain[1]));
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    chk("mid_rst_v", 32'(issue_valid), 32'h0);
    chk("mid_rst_func", 32'(func), 32'hF);
    chk("mid_rst_ready", 32'(in_ready), 32'h1);
    chk("mid_rst_fields", 32'({rs1, rs2, rd, addr}), 32'h0);
    tick();
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("mid_no_stale", 32'(issue_valid), 32'h0);
    end
    // r5 was in flight before reset; a cleared scoreboard lets this reader go at once
    drive(mk(4'd5, 4'd4, 4'd9, ADD, 8'h80));
    tick();
    in_valid = 1'b0;
    tick();
    chk("mid_post_v", 32'(issue_valid), 32'h1);
    chk("mid_post_rd", 32'(rd), 32'd9);
`ifdef PIPE_ISSUE_STATS_EN
    chk("mid_stall_cnt", 32'(stall_cnt), 32'd0);
    chk("mid_issue_cnt", 32'(issue_cnt), 32'd1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
